mult_arbiter_seq: RTL and testbench
===================================

// Module: mult_arbiter_seq
// PURPOSE
// Sequencer and round-robin arbiter for the shared 8-bit signed shift-add multiplier datapath
// (register unit + 9-bit adder/subtractor). Accepts multiply jobs from NUM_REQ requesters and
// grants one at a time. Drives the datapath's operand bus and its Clr_Ld/Add/Sub/Shift strobes,
// then captures the 2*WIDTH-bit product and returns it tagged with the requester id.
// PARAMETERS
// NUM_REQ  2  number of requesters (>=2); IDW = $clog2(NUM_REQ)
// WIDTH    8  operand width; datapath A and B registers are WIDTH bits each
// PORTS
// Clk          in   1               system clock; all state updates on rising edge
// Reset        in   1               synchronous, active-low reset
// req          in   NUM_REQ         per-requester job request, level; held until grant
// opa          in   NUM_REQ*WIDTH   multiplicand per requester, slice i = opa[i*WIDTH +: WIDTH]
// opb          in   NUM_REQ*WIDTH   multiplier per requester, same slicing
// grant        out  NUM_REQ         one-hot, 1-cycle pulse; operands latched on this cycle
// busy         out  1               high from LOAD through CAPTURE
// dp_switches  out  WIDTH           operand bus into datapath (Bin and adder input)
// dp_clr_ld    out  1               clear A/X, load B from dp_switches
// dp_add       out  1               A <= A + dp_switches
// dp_sub       out  1               A <= A - dp_switches
// dp_shift     out  1               arithmetic right shift of {X,A,B}
// dp_m         in   1               datapath M (B[0])
// a_val        in   WIDTH           datapath A register
// b_val        in   WIDTH           datapath B register
// result       out  2*WIDTH         registered product {a_val,b_val}
// result_id    out  IDW             requester index owning result
// result_valid out  1               1-cycle pulse: result/result_id valid
// BEHAVIOUR
// - Reset low (sampled at edge): FSM->IDLE, rr pointer->0 (req[0] highest priority), counter 0,
//   all outputs 0. Applies mid-job: job dropped, no result_valid, no grant.
// - dp_* strobes combinational from state; at most one of clr_ld/add/sub/shift high per cycle.
// - States: IDLE, LOAD, ADD, SHIFT, CAPTURE.
// - IDLE: if |req, pick first set req at/after rr pointer (wrapping); pulse grant, latch opa/opb
//   of winner and its id, rr pointer <= winner+1 mod NUM_REQ, -> LOAD. No req: stay.
// - LOAD (1 cyc): dp_switches=opb latched, dp_clr_ld=1, cnt<=0, -> ADD.
// - ADD (1 cyc): dp_switches=opa latched for remainder of job. If dp_m: dp_add when cnt<WIDTH-1,
//   dp_sub when cnt==WIDTH-1 (sign correction). dp_m=0: no strobe (fixed latency). -> SHIFT.
// - SHIFT (1 cyc): dp_shift=1, cnt<=cnt+1; if cnt==WIDTH-1 -> CAPTURE else -> ADD.
// - CAPTURE (1 cyc): result<={a_val,b_val}, result_id<=latched id, result_valid<=1 (seen next
//   cycle), -> IDLE.
// - Latency: grant at cycle 0 -> result_valid at cycle 2*WIDTH+3 (19 for WIDTH=8); next grant
//   earliest cycle 2*WIDTH+3, coinciding with result_valid. Throughput 1 job / 2*WIDTH+3 cyc.
// - req sampled only in IDLE; req changes while busy ignored. Requester must drop req the cycle
//   after grant; req still high on return to IDLE is a new job.
// - result/result_id hold until next CAPTURE; result_valid high exactly 1 cycle.
// - Arithmetic: two's complement, product exact for all operand pairs incl. -2^(WIDTH-1) squared.
// CONFIGURATION
// - MULT_ARB_ABORT_EN defined: adds input `abort` (1) and output `aborted` (1). abort high in
//   LOAD/ADD/SHIFT/CAPTURE -> IDLE next cycle, no result_valid, result/result_id unchanged,
//   aborted pulses 1 cycle; rr pointer keeps its post-grant value. abort in IDLE ignored (abort
//   wins over a simultaneous new req: no grant that cycle). Reset low overrides abort.
// - Not defined: ports absent; every granted job runs to completion unless Reset is low.
// TESTING
// - req=01, opa0=0xC5, opb0=0x07 -> grant=01 at c0, result_valid at c19, result=0xFE63, id=0.
// - opa0=0xFF, opb0=0xFF -> result=0x0001; opa0=0x80, opb0=0x80 -> result=0x4000.
// - req=11 held from reset -> grant 01 first, then 10 at c19; results id 0 then id 1.
// - Reset low at c5 of job -> next cycle all outputs 0, FSM IDLE, no result_valid ever for job.
// - MULT_ARB_ABORT_EN: abort at c8 -> aborted=1 at c9, busy=0, no result_valid; result unchanged.
// - Check every cycle: dp_* strobes mutually exclusive; ADD cycles with dp_m=0 have no add/sub.

Source files
------------

// File: rtl/mult_arbiter_seq.sv
// Round-robin arbiter and sequencer for the shared shift-add signed multiplier datapath.
// Optional abort support is compiled in when MULT_ARB_ABORT_EN is defined.
module mult_arbiter_seq #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   opa,
    input  logic [NUM_REQ*WIDTH-1:0]   opb,
`ifdef MULT_ARB_ABORT_EN
    input  logic                       abort,
    output logic                       aborted,
`endif
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [WIDTH-1:0]           dp_switches,
    output logic                       dp_clr_ld,
    output logic                       dp_add,
    output logic                       dp_sub,
    output logic                       dp_shift,
    input  logic                       dp_m,
    input  logic [WIDTH-1:0]           a_val,
    input  logic [WIDTH-1:0]           b_val,
    output logic [2*WIDTH-1:0]         result,
    output logic [IDW-1:0]             result_id,
    output logic                       result_valid
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ADD     = 3'd2,
        S_SHIFT   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [IDW-1:0]       result_id_q, result_id_d;
    logic                 result_valid_q, result_valid_d;
    logic                 aborted_q, aborted_d;
    logic                 abort_req;

    logic [WIDTH-1:0]     opa_arr [NUM_REQ];
    logic [WIDTH-1:0]     opb_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign opa_arr[gi] = opa[gi*WIDTH +: WIDTH];
            assign opb_arr[gi] = opb[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef MULT_ARB_ABORT_EN
    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // First asserted request at or after the round-robin pointer, wrapping around.
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] win_next;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        win_next = (int'(win) == NUM_REQ - 1) ? '0 : win + IDW'(1);
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        cnt_d          = cnt_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        id_d           = id_q;
        result_d       = result_q;
        result_id_d    = result_id_q;
        result_valid_d = 1'b0;
        aborted_d      = 1'b0;
        grant          = '0;
        busy           = 1'b0;
        dp_switches    = '0;
        dp_clr_ld      = 1'b0;
        dp_add         = 1'b0;
        dp_sub         = 1'b0;
        dp_shift       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found && !abort_req && Reset) begin
                    grant   = NUM_REQ'(1) << win;
                    opa_d   = opa_arr[win];
                    opb_d   = opb_arr[win];
                    id_d    = win;
                    rr_d    = win_next;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                dp_switches = opb_q;
                dp_clr_ld   = 1'b1;
                cnt_d       = '0;
                state_d     = S_ADD;
            end
            S_ADD: begin
                busy        = 1'b1;
                dp_switches = opa_q;
                // The multiplier's top bit carries negative weight, hence the final subtract.
                if (dp_m) begin
                    if (cnt_q == LAST_BIT) dp_sub = 1'b1;
                    else                   dp_add = 1'b1;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy        = 1'b1;
                dp_switches = opa_q;
                dp_shift    = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                state_d     = (cnt_q == LAST_BIT) ? S_CAPTURE : S_ADD;
            end
            S_CAPTURE: begin
                busy           = 1'b1;
                dp_switches    = opa_q;
                result_d       = {a_val, b_val};
                result_id_d    = id_q;
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An abort discards the job in flight, including one that is about to publish.
        if (abort_req && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            result_d       = result_q;
            result_id_d    = result_id_q;
            result_valid_d = 1'b0;
            aborted_d      = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q        <= S_IDLE;
            rr_q           <= '0;
            cnt_q          <= '0;
            opa_q          <= '0;
            opb_q          <= '0;
            id_q           <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            cnt_q          <= cnt_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            id_q           <= id_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_valid_q <= result_valid_d;
            aborted_q      <= aborted_d;
        end
    end

    assign result       = result_q;
    assign result_id    = result_id_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mult_arbiter_seq.sv
// Scoreboard bench for mult_arbiter_seq: behavioural datapath, round-robin reference model,
// and a result monitor. Abort scenarios are exercised when MULT_ARB_ABORT_EN is defined.
module tb_mult_arbiter_seq;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int LAT = 2 * W + 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   opa, opb;
    logic             abort_i;
    logic [N-1:0]     grant;
    logic             busy;
    logic [W-1:0]     dp_switches;
    logic             dp_clr_ld, dp_add, dp_sub, dp_shift;
    logic             dp_m;
    logic [W-1:0]     a_val, b_val;
    logic [2*W-1:0]   result;
    logic [0:0]       result_id;
    logic             result_valid;
    logic             aborted;

    always #5 clk = ~clk;

    mult_arbiter_seq #(.NUM_REQ(N), .WIDTH(W)) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .req          (req),
        .opa          (opa),
        .opb          (opb),
`ifdef MULT_ARB_ABORT_EN
        .abort        (abort_i),
        .aborted      (aborted),
`endif
        .grant        (grant),
        .busy         (busy),
        .dp_switches  (dp_switches),
        .dp_clr_ld    (dp_clr_ld),
        .dp_add       (dp_add),
        .dp_sub       (dp_sub),
        .dp_shift     (dp_shift),
        .dp_m         (dp_m),
        .a_val        (a_val),
        .b_val        (b_val),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid)
    );

`ifndef MULT_ARB_ABORT_EN
    assign aborted = 1'b0;
`endif

    // Behavioural register unit: X sign bit, A accumulator, B multiplier, 9-bit add/sub.
    logic           dp_x = 1'b0;
    logic [W-1:0]   dp_a = '0;
    logic [W-1:0]   dp_b = '0;
    assign a_val = dp_a;
    assign b_val = dp_b;
    assign dp_m  = dp_b[0];

    always @(posedge clk) begin
        if (dp_clr_ld) begin
            dp_x <= 1'b0;
            dp_a <= '0;
            dp_b <= dp_switches;
        end else if (dp_add) begin
            {dp_x, dp_a} <= {dp_a[W-1], dp_a} + {dp_switches[W-1], dp_switches};
        end else if (dp_sub) begin
            {dp_x, dp_a} <= {dp_a[W-1], dp_a} - {dp_switches[W-1], dp_switches};
        end else if (dp_shift) begin
            dp_a <= {dp_x, dp_a[W-1:1]};
            dp_b <= {dp_a[0], dp_b[W-1:1]};
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa, pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return (2*W)'(pa * pb);
    endfunction

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    exp_t       sb_q[$];
    int         busy_left    = 0;
    int         model_rr     = 0;
    logic       aborted_pend = 1'b0;
    logic [N-1:0] last_grant = '0;

    // Reference arbiter: grant decision, busy window, abort and reset effects.
    always @(negedge clk) begin
        logic [N-1:0] expg;
        int           win;
        expg = '0;
        win  = 0;
        if (rst_n && busy_left == 0 && req != '0 && !abort_i) begin
            for (int k = N - 1; k >= 0; k--)
                if (req[(model_rr + k) % N]) win = (model_rr + k) % N;
            expg = N'(1) << win;
        end
        last_grant = grant;
        check("grant", 32'(grant), 32'(expg));
        check("busy", 32'(busy), 32'(busy_left > 0));
        check("aborted", 32'(aborted), 32'(aborted_pend));
        check("strobe_excl", 32'($countones({dp_clr_ld, dp_add, dp_sub, dp_shift}) <= 1), 32'd1);
        if (!dp_m) check("m0_addsub", 32'({dp_add, dp_sub}), 32'd0);
        if (busy_left == 0) check("idle_strobes", 32'({dp_clr_ld, dp_add, dp_sub, dp_shift}), 32'd0);

        if (!rst_n) begin
            busy_left    = 0;
            model_rr     = 0;
            aborted_pend = 1'b0;
        end else if (abort_i && busy_left > 0) begin
            busy_left    = 0;
            aborted_pend = 1'b1;
            void'(sb_q.pop_back());
        end else begin
            aborted_pend = 1'b0;
            if (expg != '0) begin
                exp_t e;
                e.id   = win;
                e.prod = ref_mul(opa[win*W +: W], opb[win*W +: W]);
                e.due  = cyc + LAT;
                sb_q.push_back(e);
                $display("grant req=%0d a=%h b=%h expect=%h cycle=%0d",
                         win, opa[win*W +: W], opb[win*W +: W], e.prod, cyc);
                busy_left = LAT - 1;
                model_rr  = (win + 1) % N;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
    end

    logic [2*W-1:0] last_res = '0;
    logic [0:0]     last_id  = '0;

    // Result monitor: pops the scoreboard whenever a result is due or presented.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        if (result_valid || exp_v) begin
            check("result_valid", 32'(result_valid), 32'(exp_v));
            if (exp_v) begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e.prod));
                check("result_id", 32'(result_id), 32'(e.id));
                $display("result id=%0d prod=%h expect=%h cycle=%0d", result_id, result, e.prod, cyc);
                last_res = e.prod;
                last_id  = 1'(e.id);
            end
        end else begin
            check("result_hold", 32'(result), 32'(last_res));
            check("result_id_hold", 32'(result_id), 32'(last_id));
        end
        if (!rst_n) begin
            sb_q.delete();
            last_res = '0;
            last_id  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (last_grant[i]) req[i] = 1'b0;
    endtask

    task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req[i]         = 1'b1;
        opa[i*W +: W]  = a;
        opb[i*W +: W]  = b;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            tick();
            done = (req == '0) && (busy_left == 0) && (sb_q.size() == 0);
        end
        check("drain", 32'(done), 32'd1);
    endtask

    task automatic wait_grant();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            tick();
            seen = (last_grant != '0);
        end
        check("grant_seen", 32'(seen), 32'd1);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] corners [5];
        corners = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
        if ($urandom_range(7) == 0) return corners[$urandom_range(4)];
        return W'($urandom);
    endfunction

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        opa     = '0;
        opb     = '0;
        abort_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        raise(0, 8'hC5, 8'h07);
        drain();
        raise(0, 8'hFF, 8'hFF);
        drain();
        raise(0, 8'h80, 8'h80);
        drain();
        raise(1, 8'h7F, 8'h80);
        drain();

        // Both requesters held from reset: requester 0 wins first.
        rst_n = 1'b0;
        raise(0, 8'h12, 8'hF3);
        raise(1, 8'h9A, 8'h65);
        tick();
        rst_n = 1'b1;
        drain();

        // Reset in the middle of a job drops it.
        raise(1, 8'h55, 8'hAA);
        wait_grant();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (25) tick();

`ifdef MULT_ARB_ABORT_EN
        raise(0, 8'h33, 8'hC1);
        wait_grant();
        repeat (7) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        repeat (3) tick();
        raise(1, 8'h44, 8'h21);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        drain();
`endif

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && !last_grant[i] && $urandom_range(3) == 0)
                    raise(i, rnd_op(), rnd_op());
`ifdef MULT_ARB_ABORT_EN
            abort_i = ($urandom_range(49) == 0);
`endif
            tick();
        end
        abort_i = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
